instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Front-end fetch stage of the in-order RISC-V core; producer side of the instruction stream consumed by `instruction_decoder`. It maintains the PC and issues word reads to instruction memory over a valid/ready request channel with in-order responses. Returned words are buffered in a small prefetch FIFO and presented to ID with their PC. Redirects from EX (branch/jump) flush the FIFO and discard in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, prefetch entries and max outstanding requests (power of 2, ≥2)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high
- `imem_req_valid` out 1: request valid
- `imem_req_ready` in 1: memory accepts the request
- `imem_req_addr` out 32: word address, bits [1:0] always 0
- `imem_rsp_valid` in 1: response valid; responses in request order, ≥1 cycle after acceptance, no backpressure
- `imem_rsp_data` in 32: instruction word
- `imem_rsp_err` in 1: bus/access error for this response
- `redirect_valid` in 1: EX redirect pulse
- `redirect_pc` in 32: redirect target
- `id_ready` in 1: ID consumes the head entry this cycle
- `if_valid` out 1: head entry valid
- `if_instr` out 32: instruction (32'h0000_0013 NOP when `if_fault`=1)
- `if_pc` out 32: PC of the instruction
- `if_fault` out 1: entry carries a fetch fault
- `if_fault_cause` out 1: 0 = misaligned target, 1 = access error

## Operation
- FSM states: IDLE, FETCH, HALT. Reset enters IDLE. IDLE→FETCH unconditionally after one cycle.
- FETCH: `imem_req_valid`=1 when `outstanding + fifo_count < FIFO_DEPTH` and no redirect this cycle. `imem_req_addr`=`fetch_pc`. On handshake: `fetch_pc += 4`, `outstanding++`. Wrap-around: 32'hFFFF_FFFC+4 = 0, no fault.
- Response: `outstanding--`. When `discard_cnt`>0: `discard_cnt--` and drop the word. Otherwise push {data, pc, err} into the FIFO, with pc from a FIFO-aligned PC queue or `resp_pc` counter (+4 per push).
- Error response: push a fault entry (cause=1), go to HALT. HALT issues no requests. Later responses are still counted and dropped.
- Redirect (any state): flush FIFO, `discard_cnt := outstanding - (rsp this cycle ? 1 : 0)`, `fetch_pc := redirect_pc`, `resp_pc := redirect_pc`. If `redirect_pc[1:0]`≠0: push a single fault entry (cause=0, `if_pc`=`redirect_pc`) on the next cycle and go to HALT. Otherwise go to FETCH.
- Pop when `if_valid && id_ready`. Push and pop may occur in the same cycle. A full FIFO is impossible by the credit rule.
- Redirect has priority over any push or pop in the same cycle. The head is not consumed by ID.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=32'h13, `if_pc`=0, `if_fault`=0, `if_fault_cause`=0. `outstanding`, `discard_cnt`, and `fifo_count` are all 0.
- First request: second rising edge after `reset` falls (one cycle in IDLE).
- `imem_req_*` are registered outputs, held stable while valid and not ready.
- Response→`if_valid` latency: 1 cycle (FIFO write, registered head).
- Redirect at edge N: `imem_req_valid`=0 in cycle N, new-target request in cycle N+1, `if_valid`=0 in cycle N+1.
- Reset mid-operation: all state cleared immediately. In-flight responses after reset are not tracked; memory is reset together with the core.

## Configuration
- `IFU_PREFETCH_EN` defined: FIFO holds `FIFO_DEPTH` entries, up to `FIFO_DEPTH` requests outstanding, back-to-back requests every cycle.
- Not defined: effective depth 1, at most one request outstanding, new request only after the entry is popped. This gives 1 instruction per ≥3 cycles; functional behaviour is otherwise identical.

## Structure
- Shared `core_pkg`: `ifu_state_e` (IDLE/FETCH/HALT), `NOP_INSTR`=32'h0000_0013, `FAULT_MISALIGNED`/`FAULT_ACCESS` cause encodings, `ifu_entry_t` {instr, pc, fault, cause}.
- One sub-module: `ifu_fifo`, a parameterized synchronous FIFO of `ifu_entry_t` with flush, push, pop, count, and registered head.

## Test plan
- Reset release, memory always ready, 1-cycle latency → requests 0x0, 0x4, 0x8 on consecutive cycles; ID sees the same PCs in order with matching data.
- `id_ready`=0 for 10 cycles → at most `FIFO_DEPTH` requests issued, `if_valid` held with a stable head; resumes without loss when `id_ready`=1.
- Redirect to 0x100 with 2 responses outstanding → both dropped; next `if_pc`=0x100; no entry from the old path reaches ID.
- Redirect to 0x102 → no request; a single entry with `if_fault`=1, cause=0, `if_pc`=0x102, `if_instr`=0x13; FSM in HALT until the next redirect.
- Response with `imem_rsp_err`=1 at PC 0x8 → fault entry cause=1, `if_pc`=0x8; no further requests; redirect to 0x20 resumes fetch.
- `fetch_pc`=0xFFFF_FFFC → next request address 0x0000_0000, no fault.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the in-order core front end.
// Holds the fetch FSM states, the fault-cause encodings and the prefetch entry type.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } ifu_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic        FAULT_MISALIGNED = 1'b0;
   localparam logic        FAULT_ACCESS     = 1'b1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
      logic        cause;
   } ifu_entry_t;

   localparam ifu_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: 32'h0, fault: 1'b0, cause: 1'b0};

   // Fault entries always carry a NOP so a decoder that ignores the flag stays harmless.
   function automatic ifu_entry_t make_fault(input logic [31:0] pc, input logic cause);
      ifu_entry_t e;
      e.instr = NOP_INSTR;
      e.pc    = pc;
      e.fault = 1'b1;
      e.cause = cause;
      return e;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of fetch entries with flush; head is read straight from flops.
// An empty FIFO presents a NOP entry at PC 0.
module ifu_fifo
   import core_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_flush,
   input  logic          i_push,
   input  ifu_entry_t    i_push_data,
   input  logic          i_pop,
   output ifu_entry_t    o_head,
   output logic          o_valid,
   output logic [CW-1:0] o_count
);
   localparam int AW = $clog2(DEPTH);

   ifu_entry_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Flush wins over a simultaneous push or pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_valid = (r_count != '0);
   assign o_head  = o_valid ? r_mem[r_rd_ptr] : EMPTY_ENTRY;
   assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues in-order word reads, buffers responses and hands them to ID with their PC.
// Define IFU_PREFETCH_EN to let the prefetch FIFO and outstanding requests use the full FIFO_DEPTH.
module instruction_fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_fault,
   output logic        if_fault_cause
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef IFU_PREFETCH_EN
   localparam int EFF_DEPTH = FIFO_DEPTH;
`else
   localparam int EFF_DEPTH = 1;
`endif
   localparam logic [CW:0] EFF_LIMIT = (CW+1)'(EFF_DEPTH);

   ifu_state_e    r_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard_cnt;
   logic          r_req_valid;
   logic          r_misalign_pend;

   logic          w_req_fire;
   logic          w_rsp_keep;
   logic          w_push;
   logic          w_pop;
   logic          w_head_valid;
   ifu_entry_t    w_push_entry;
   ifu_entry_t    w_head;
   logic [CW-1:0] w_fifo_count;
   logic [CW-1:0] w_out_next;
   logic [CW-1:0] w_count_next;
   logic [CW:0]   w_credit;

   assign w_req_fire   = r_req_valid & imem_req_ready;
   assign w_rsp_keep   = imem_rsp_valid & ~redirect_valid & (r_state == FETCH) & (r_discard_cnt == '0);
   assign w_push       = w_rsp_keep | (r_misalign_pend & ~redirect_valid);
   assign w_pop        = w_head_valid & id_ready & ~redirect_valid;
   assign w_out_next   = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
   assign w_count_next = w_fifo_count + CW'(w_push) - CW'(w_pop);
   // Credits count both in-flight words and buffered ones, so the FIFO can never overflow.
   assign w_credit     = {1'b0, w_out_next} + {1'b0, w_count_next};

   always_comb begin
      w_push_entry = '{instr: imem_rsp_data, pc: r_resp_pc, fault: 1'b0, cause: 1'b0};
      if (r_misalign_pend) begin
         w_push_entry = make_fault(r_resp_pc, FAULT_MISALIGNED);
      end else if (imem_rsp_err) begin
         w_push_entry = make_fault(r_resp_pc, FAULT_ACCESS);
      end
   end

   ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (redirect_valid),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_valid     (w_head_valid),
      .o_count     (w_fifo_count)
   );

   // Discard count includes a request accepted on the redirect edge itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_fetch_pc      <= RESET_PC;
         r_resp_pc       <= RESET_PC;
         r_outstanding   <= '0;
         r_discard_cnt   <= '0;
         r_req_valid     <= 1'b0;
         r_misalign_pend <= 1'b0;
      end else begin
         r_outstanding <= w_out_next;
         if (redirect_valid) begin
            r_discard_cnt   <= w_out_next;
            r_fetch_pc      <= redirect_pc;
            r_resp_pc       <= redirect_pc;
            r_req_valid     <= 1'b0;
            r_misalign_pend <= (redirect_pc[1:0] != 2'b00);
            r_state         <= (redirect_pc[1:0] != 2'b00) ? HALT : FETCH;
         end else begin
            r_misalign_pend <= 1'b0;
            if (imem_rsp_valid && r_discard_cnt != '0) r_discard_cnt <= r_discard_cnt - CW'(1);
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push)     r_resp_pc  <= r_resp_pc + 32'd4;
            case (r_state)
               IDLE: begin
                  r_state     <= FETCH;
                  r_req_valid <= 1'b0;
               end
               FETCH: begin
                  if (w_rsp_keep && imem_rsp_err) begin
                     r_state     <= HALT;
                     r_req_valid <= 1'b0;
                  end else if (!(r_req_valid && !imem_req_ready)) begin
                     r_req_valid <= (w_credit < EFF_LIMIT);
                  end
               end
               HALT: r_req_valid <= 1'b0;
               default: begin
                  r_state     <= IDLE;
                  r_req_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = {r_fetch_pc[31:2], 2'b00};
   assign if_valid       = w_head_valid;
   assign if_instr       = w_head.instr;
   assign if_pc          = w_head.pc;
   assign if_fault       = w_head.fault;
   assign if_fault_cause = w_head.cause;

endmodule
